// File: rtl/mux_nx1_scan.sv
// rtl/mux_nx1_scan.sv - registered N-to-1 channel mux with manual, scan and hold modes
//
// Purpose: selects one of NCH W-bit channels onto a registered output. In
// manual mode the channel follows sel; in scan mode the channel advances
// round-robin every SCAN_DIV clocks; hold freezes the channel index and the
// scan divider while dout keeps tracking the frozen channel's data.
//
// Ports:
//   clk_2   in   1        system clock, rising edge
//   rst_n   in   1        asynchronous active-low reset
//   din     in   NCH*W    packed channels, channel k = din[k*W +: W]
//   sel     in   SELW     manual channel select (out-of-range values ignored)
//   mode    in   1        0 = manual, 1 = scan
//   hold    in   1        1 = freeze channel index and scan divider
//   dout    out  W        registered selected data
//   cur_ch  out  SELW     channel currently driving dout
//   valid   out  1        dout meaningful (set from the first edge after reset)
//   wrap    out  1        one-cycle pulse when scan steps NCH-1 -> 0
module mux_nx1_scan #(
  parameter  int NCH      = 4,
  parameter  int W        = 2,
  parameter  int SCAN_DIV = 50000000,
  localparam int SELW     = $clog2(NCH)
) (
  input  logic              clk_2,
  input  logic              rst_n,
  input  logic [NCH*W-1:0]  din,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  input  logic              hold,
  output logic [W-1:0]      dout,
  output logic [SELW-1:0]   cur_ch,
  output logic              valid,
  output logic              wrap
);

  localparam int DIVW = $clog2(SCAN_DIV + 1);
  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(SCAN_DIV - 1);
  localparam logic [SELW-1:0] CH_LAST   = SELW'(NCH - 1);
  localparam logic [SELW:0]   SEL_LIMIT = (SELW + 1)'(NCH);

  typedef enum logic [1:0] {ST_MAN, ST_SCAN, ST_HOLD} state_t;

  state_t          state_q, state_d;
  logic [DIVW-1:0] div_q, div_d, div_base;
  logic [SELW-1:0] cur_ch_q, ch_next;
  logic [W-1:0]    dout_q, din_sel;
  logic            valid_q, wrap_q, wrap_d;

  // State register
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MAN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: hold has priority over mode, decided fresh on every edge
  always_comb begin
    state_d = ST_MAN;
    if (hold) begin
      state_d = ST_HOLD;
    end else if (mode) begin
      state_d = ST_SCAN;
    end
  end

  // Output / datapath decisions for the state being entered on this edge,
  // so mode, hold and sel all take effect with one cycle of latency.
  always_comb begin
    ch_next  = cur_ch_q;
    div_d    = div_q;
    div_base = div_q;
    wrap_d   = 1'b0;
    unique case (state_d)
      ST_MAN: begin
        div_d = '0;
        if ({1'b0, sel} < SEL_LIMIT) begin
          ch_next = sel;
        end
      end
      ST_SCAN: begin
        // Entry from manual always counts from zero; entry from hold resumes.
        div_base = (state_q == ST_MAN) ? '0 : div_q;
        if (div_base == DIV_LAST) begin
          div_d = '0;
          // Explicit compare keeps non-power-of-2 NCH from reaching index NCH.
          if (cur_ch_q == CH_LAST) begin
            ch_next = '0;
            wrap_d  = 1'b1;
          end else begin
            ch_next = cur_ch_q + SELW'(1);
          end
        end else begin
          div_d = div_base + DIVW'(1);
        end
      end
      default: begin
        // ST_HOLD: index and divider frozen, wrap stays low
      end
    endcase
  end

  // Channel mux on the next index so dout and cur_ch update together
  always_comb begin
    din_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_next == SELW'(k)) begin
        din_sel = din[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch_q <= '0;
      dout_q   <= '0;
      div_q    <= '0;
      wrap_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      cur_ch_q <= ch_next;
      dout_q   <= din_sel;
      div_q    <= div_d;
      wrap_q   <= wrap_d;
      valid_q  <= 1'b1;
    end
  end

  assign dout   = dout_q;
  assign cur_ch = cur_ch_q;
  assign valid  = valid_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb/tb_mux_nx1_scan.sv - directed self-checking bench for mux_nx1_scan
module tb_mux_nx1_scan;

  localparam logic [7:0] STD4 = 8'b11_10_01_00;
  localparam logic [5:0] STD3 = 6'b10_01_00;

  logic       clk_2 = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic [1:0] sel;
  logic       mode, hold;
  logic [1:0] dout, cur_ch;
  logic       valid, wrap;

  logic [5:0] din3;
  logic [1:0] sel3;
  logic       mode3, hold3;
  logic [1:0] dout3, cur_ch3;
  logic       valid3, wrap3;

  int tests = 0;
  int fails = 0;

  always #5 clk_2 = ~clk_2;

  mux_nx1_scan #(.NCH(4), .W(2), .SCAN_DIV(3)) dut4 (
    .clk_2(clk_2), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode), .hold(hold),
    .dout(dout), .cur_ch(cur_ch), .valid(valid), .wrap(wrap)
  );

  mux_nx1_scan #(.NCH(3), .W(2), .SCAN_DIV(3)) dut3 (
    .clk_2(clk_2), .rst_n(rst_n), .din(din3), .sel(sel3), .mode(mode3), .hold(hold3),
    .dout(dout3), .cur_ch(cur_ch3), .valid(valid3), .wrap(wrap3)
  );

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din = 8'($urandom); sel = 2'($urandom); mode = 1'($urandom); hold = 1'($urandom);
    din3 = STD3; sel3 = 2'd0; mode3 = 1'b0; hold3 = 1'b0;
    tick(); tick();
    tests++; if (dout !== 2'd0) begin fails++; $display("FAIL reset_dout got %0d exp 0", dout); end
    tests++; if (cur_ch !== 2'd0) begin fails++; $display("FAIL reset_cur_ch got %0d exp 0", cur_ch); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0d exp 0", valid); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got %0d exp 0", wrap); end
    din = STD4; sel = 2'd0; mode = 1'b0; hold = 1'b0;
    rst_n = 1'b1;
    #2;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL valid_before_edge got %0d exp 0", valid); end
    tick();
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL valid_after_edge got %0d exp 1", valid); end
    tests++; if (cur_ch !== 2'd0) begin fails++; $display("FAIL release_cur_ch got %0d exp 0", cur_ch); end
  endtask

  task automatic test_manual();
    sel = 2'd2;
    tick();
    tests++; if (cur_ch !== 2'd2) begin fails++; $display("FAIL man_cur_ch got %0d exp 2", cur_ch); end
    tests++; if (dout !== 2'b10) begin fails++; $display("FAIL man_dout got %0d exp 2", dout); end
    din[5:4] = 2'b01;
    tick();
    tests++; if (dout !== 2'b01) begin fails++; $display("FAIL man_din_track got %0d exp 1", dout); end
    din = STD4; sel = 2'd3;
    tick();
    tests++; if (dout !== 2'b11) begin fails++; $display("FAIL man_sel3 got %0d exp 3", dout); end
  endtask

  task automatic test_scan();
    logic [1:0] exp_ch;
    sel = 2'd1;
    tick();
    tests++; if (cur_ch !== 2'd1) begin fails++; $display("FAIL scan_start got %0d exp 1", cur_ch); end
    mode = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_ch = 2'((1 + i / 3) % 4);
      tests++; if (cur_ch !== exp_ch) begin fails++; $display("FAIL scan_ch edge %0d got %0d exp %0d", i, cur_ch, exp_ch); end
      tests++; if (dout !== exp_ch) begin fails++; $display("FAIL scan_dout edge %0d got %0d exp %0d", i, dout, exp_ch); end
      tests++; if (wrap !== (i == 9)) begin fails++; $display("FAIL scan_wrap edge %0d got %0d exp %0d", i, wrap, (i == 9)); end
    end
  endtask

  task automatic test_hold();
    logic [1:0] exp_d;
    tick();  // one scan cycle after the step to ch1
    hold = 1'b1;
    sel = 2'd3;
    for (int h = 0; h < 5; h++) begin
      if (h == 2) din[3:2] = 2'b10;
      tick();
      exp_d = (h >= 2) ? 2'b10 : 2'b01;
      tests++; if (cur_ch !== 2'd1) begin fails++; $display("FAIL hold_ch cycle %0d got %0d exp 1", h, cur_ch); end
      tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL hold_wrap cycle %0d got %0d exp 0", h, wrap); end
      tests++; if (dout !== exp_d) begin fails++; $display("FAIL hold_dout cycle %0d got %0d exp %0d", h, dout, exp_d); end
    end
    din = STD4; hold = 1'b0;
    tick();
    tests++; if (cur_ch !== 2'd1) begin fails++; $display("FAIL resume1 got %0d exp 1", cur_ch); end
    tick();
    tests++; if (cur_ch !== 2'd2) begin fails++; $display("FAIL resume2 got %0d exp 2", cur_ch); end
  endtask

  task automatic test_priority();
    hold = 1'b1; mode = 1'b0; sel = 2'd3;
    tick();
    tests++; if (cur_ch !== 2'd2) begin fails++; $display("FAIL prio_hold got %0d exp 2", cur_ch); end
    hold = 1'b0;
    tick();
    tests++; if (cur_ch !== 2'd3) begin fails++; $display("FAIL hold_to_man got %0d exp 3", cur_ch); end
    tests++; if (dout !== 2'b11) begin fails++; $display("FAIL hold_to_man_dout got %0d exp 3", dout); end
  endtask

  task automatic test_nch3();
    logic [1:0] exp_ch;
    sel3 = 2'd1;
    tick();
    tests++; if (cur_ch3 !== 2'd1) begin fails++; $display("FAIL n3_sel1 got %0d exp 1", cur_ch3); end
    sel3 = 2'd3;
    tick();
    tests++; if (cur_ch3 !== 2'd1) begin fails++; $display("FAIL n3_badsel got %0d exp 1", cur_ch3); end
    tests++; if (dout3 !== 2'b01) begin fails++; $display("FAIL n3_badsel_dout got %0d exp 1", dout3); end
    mode3 = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp_ch = 2'((1 + i / 3) % 3);
      tests++; if (cur_ch3 !== exp_ch) begin fails++; $display("FAIL n3_scan edge %0d got %0d exp %0d", i, cur_ch3, exp_ch); end
      tests++; if (wrap3 !== (i == 6)) begin fails++; $display("FAIL n3_wrap edge %0d got %0d exp %0d", i, wrap3, (i == 6)); end
    end
  endtask

  task automatic test_async_reset();
    mode = 1'b1;
    tick(); tick();
    tests++; if (cur_ch !== 2'd3) begin fails++; $display("FAIL pre_reset_ch got %0d exp 3", cur_ch); end
    #3 rst_n = 1'b0;
    #1;
    tests++; if (dout !== 2'd0) begin fails++; $display("FAIL async_dout got %0d exp 0", dout); end
    tests++; if (cur_ch !== 2'd0) begin fails++; $display("FAIL async_ch got %0d exp 0", cur_ch); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL async_valid got %0d exp 0", valid); end
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests++; if (cur_ch !== ((i >= 3) ? 2'd1 : 2'd0)) begin fails++; $display("FAIL post_reset_scan edge %0d got %0d exp %0d", i, cur_ch, (i >= 3) ? 1 : 0); end
    end
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL post_reset_valid got %0d exp 1", valid); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_hold();
    test_priority();
    test_nch3();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
- Parametrised, registered N-to-1 multiplexer. It generalises the single-bit 2x1 select to NCH channels of W bits each.
- Adds two modes: manual select, and an automatic round-robin scan mode driven by a clock divider.
- Adds a hold/freeze control and a wrap pulse.
- Sits behind the board switches and drives LEDs/SEG and the lcd debug outputs in top-level experiments.

Parameters:
- NCH, 4, number of input channels (>=2).
- W, 2, bits per channel.
- SCAN_DIV, 50000000, clk_2 cycles per channel step in scan mode (>=1).
- SELW, $clog2(NCH), select/channel index width (localparam, derived).

Ports:
- clk_2  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  NCH*W  packed channels; channel k = din[k*W +: W].
- sel  input  SELW  manual channel select.
- mode  input  1  0 = manual, 1 = scan.
- hold  input  1  1 = freeze the channel index (and the scan counter).
- dout  output  W  registered selected data.
- cur_ch  output  SELW  channel currently driving dout.
- valid  output  1  dout meaningful.
- wrap  output  1  one-cycle pulse on scan wrap NCH-1 -> 0.

Behaviour:
- Reset: on rst_n low (async, immediate), the following are 0: dout, cur_ch, valid, wrap, div_cnt, and state (MAN).
- After rst_n rises, valid goes to 1 at the first clk_2 edge and stays 1 until the next reset.
- Datapath: each edge computes ch_next, then cur_ch <= ch_next and dout <= din[ch_next].
  - dout and cur_ch are always mutually consistent.
  - Latency from din or sel to dout is 1 cycle.
- FSM states MAN, SCAN, HOLD, evaluated each edge:
  - hold=1 -> HOLD.
  - hold=0 and mode=0 -> MAN.
  - hold=0 and mode=1 -> SCAN.
- MAN:
  - If sel < NCH, ch_next = sel; otherwise ch_next = cur_ch (out-of-range sel ignored).
  - div_cnt is forced to 0.
- SCAN:
  - div_cnt counts 0..SCAN_DIV-1.
  - At div_cnt == SCAN_DIV-1: div_cnt <= 0 and ch_next = (cur_ch == NCH-1) ? 0 : cur_ch+1. Otherwise div_cnt++ and ch_next = cur_ch.
  - wrap <= 1 only on the step from NCH-1 to 0; otherwise wrap <= 0.
  - SCAN_DIV=1 steps every cycle.
- HOLD:
  - ch_next = cur_ch; div_cnt frozen; wrap <= 0.
  - dout keeps tracking din of cur_ch every cycle.
  - sel and mode are ignored.
- Transitions:
  - MAN->SCAN: scan starts from the current cur_ch, with div_cnt = 0 at the first SCAN cycle. The first step comes SCAN_DIV cycles after entry.
  - SCAN->MAN: the channel is taken from sel at the next edge; div_cnt cleared.
  - HOLD->SCAN: div_cnt resumes from its frozen value; it is not cleared.
  - HOLD->MAN: sel is applied at the next edge.
  - Mode and hold changing on the same edge: the priority order above applies (hold wins).
- Reset asserted mid-scan: everything returns to its reset value immediately. After release the block is in MAN with cur_ch=0, regardless of mode.
- Widths:
  - The channel increment uses SELW bits with explicit compare to NCH-1, so non-power-of-2 NCH never reaches index NCH.
  - div_cnt width is $clog2(SCAN_DIV+1).
- No combinational path from inputs to outputs.

Test Plan:
All scenarios use NCH=4, W=2, SCAN_DIV=3, with din = {ch3=2'b11, ch2=2'b10, ch1=2'b01, ch0=2'b00} unless noted.
- Reset: hold rst_n=0 with random inputs -> dout=0, cur_ch=0, valid=0, wrap=0. Release -> valid=1 after the first edge.
- Manual select: mode=0, hold=0, sel=2 -> one edge later cur_ch=2 and dout=2'b10. Change din ch2 to 2'b01 -> dout=2'b01 one cycle later.
- Scan from MAN cur_ch=1: set mode=1.
  - cur_ch steps to 2, 3, 0, 1 every 3 cycles.
  - wrap=1 for exactly the one cycle in which cur_ch becomes 0.
- Hold mid-scan: in SCAN, assert hold one cycle after a step, keep it 5 cycles, then release.
  - During hold: cur_ch unchanged, wrap=0, dout follows din of cur_ch.
  - After release: the next step comes 2 cycles later (div_cnt resumed).
- Bad sel / NCH=3 variant:
  - Manual sel=3 with NCH=3 -> cur_ch holds its previous value.
  - Scan with NCH=3 wraps 2 -> 0, never reaching 3.
- Async reset mid-scan: pull rst_n low between edges -> outputs go to 0 before the next edge. After release with mode=1 held -> cur_ch=0, and first step SCAN_DIV cycles after SCAN entry.
